vga_timing_gen: RTL

//  Generates the 640x480@60Hz VGA raster that display_controller paints against.
//  - Divides the system clock down to a pixel-rate enable.
//  - Drives raw hCount/vCount, active-low hSync/vSync, bright and a one-cycle frameStart.
//  - Counts frames for animation timing.
//  - Sits between the board top level and the display/painting logic.

---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 22 ++
 rtl/vga_timing_gen_pixel_tick_gen.sv | 26 ++
 rtl/vga_timing_gen.sv | 81 ++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60Hz raster constants and types for the VGA timing generator and its consumers.
package vga_timing_gen_pkg;

  localparam int CNT_W   = 10;
  localparam int FRAME_W = 8;

  localparam int CLK_DIV_DEF     = 4;
  localparam int H_TOTAL_DEF     = 800;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_ACT_START_DEF = 144;
  localparam int H_ACT_END_DEF   = 784;
  localparam int V_TOTAL_DEF     = 525;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_ACT_START_DEF = 35;
  localparam int V_ACT_END_DEF   = 515;

  typedef logic [CNT_W-1:0]   cnt_t;
  typedef logic [FRAME_W-1:0] frame_t;

  // Half-open window test used for every sync/active decode.
  function automatic logic in_span(cnt_t val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to the painting logic.
interface vga_timing_gen_if
  import vga_timing_gen_pkg::*;
;
  logic   pixelTick;
  cnt_t   hCount;
  cnt_t   vCount;
  logic   hSync;
  logic   vSync;
  logic   bright;
  logic   frameStart;
  frame_t frameCount;

  modport master (
    output pixelTick, hCount, vCount, hSync, vSync, bright, frameStart, frameCount
  );

  modport slave (
    input pixelTick, hCount, vCount, hSync, vSync, bright, frameStart, frameCount
  );

endinterface

// File: rtl/vga_timing_gen_pixel_tick_gen.sv
// Divides the system clock down to a registered one-clock pixel-rate strobe.
module pixel_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pixelTick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div;

  // With CLK_DIV==1 div sits at 0 == DIV_LAST, so the strobe stays high after the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div       <= '0;
      pixelTick <= 1'b0;
    end else begin
      pixelTick <= (div == DIV_LAST);
      div       <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel counters, zero-skew sync/active decode and a frame counter.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_ACT_START = H_ACT_START_DEF,
  parameter int H_ACT_END   = H_ACT_END_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_ACT_START = V_ACT_START_DEF,
  parameter int V_ACT_END   = V_ACT_END_DEF
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  logic   tick;
  cnt_t   h_cnt, v_cnt;
  cnt_t   h_nxt, v_nxt;
  logic   line_end, frame_end;
  logic   hsync_r, vsync_r, bright_r, frame_start_r;
  frame_t frame_cnt;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .pixelTick (tick)
  );

  always_comb begin
    line_end  = (h_cnt == cnt_t'(H_TOTAL - 1));
    frame_end = line_end && (v_cnt == cnt_t'(V_TOTAL - 1));
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    if (tick) begin
      h_nxt = line_end ? '0 : h_cnt + cnt_t'(1);
      if (line_end) begin
        v_nxt = (v_cnt == cnt_t'(V_TOTAL - 1)) ? '0 : v_cnt + cnt_t'(1);
      end
    end
  end

  // Register stage: sync/bright decode the next-state counts so they line up with the counts they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      hsync_r       <= 1'b0;
      vsync_r       <= 1'b0;
      bright_r      <= 1'b0;
      frame_start_r <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      h_cnt         <= h_nxt;
      v_cnt         <= v_nxt;
      hsync_r       <= !in_span(h_nxt, 0, H_SYNC);
      vsync_r       <= !in_span(v_nxt, 0, V_SYNC);
      bright_r      <= in_span(h_nxt, H_ACT_START, H_ACT_END) &&
                       in_span(v_nxt, V_ACT_START, V_ACT_END);
      frame_start_r <= tick && frame_end;
      if (tick && frame_end) begin
        frame_cnt <= frame_cnt + frame_t'(1);
      end
    end
  end

  assign vga.pixelTick  = tick;
  assign vga.hCount     = h_cnt;
  assign vga.vCount     = v_cnt;
  assign vga.hSync      = hsync_r;
  assign vga.vSync      = vsync_r;
  assign vga.bright     = bright_r;
  assign vga.frameStart = frame_start_r;
  assign vga.frameCount = frame_cnt;

endmodule
